// File: rtl/gray_window_3x3.sv
// gray_window_3x3: streaming 3x3 neighbourhood generator.
// Buffers the two previous image lines and presents, for every accepted
// pixel whose window lies fully inside the image, the 3x3 window centred
// one row and one column behind the newest pixel. Pixel data is passed
// through bit-exact; no arithmetic is applied to it.
module gray_window_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  gray_in,
    input  logic        in_valid,
    input  logic        in_sof,
    output logic [71:0] win_out,
    output logic        win_valid,
    output logic        frame_done
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_FIRST_WIN = ROW_W'(2);

    typedef logic [7:0] pixel_t;

    // Position of the pixel currently being accepted.
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] pos_col;
    logic [ROW_W-1:0] pos_row;

    // Line buffers: l1 holds the previous line, l2 the line before that.
    pixel_t l1_mem [IMG_WIDTH];
    pixel_t l2_mem [IMG_WIDTH];
    pixel_t l1_rd;
    pixel_t l2_rd;

    // Column history per window row. Index 1 is the most recent stored
    // column; the newest (rightmost) column is the live column made of the
    // line-buffer read data and gray_in, so together they span three columns.
    pixel_t top_sr [2];
    pixel_t mid_sr [2];
    pixel_t bot_sr [2];

    logic        accept;
    logic        win_hit;
    logic        last_hit;
    logic [71:0] win_next;

    // Reset has priority, so nothing is accepted while rst_n is low.
    assign accept = in_valid && rst_n;

    // Start-of-frame forces the accepted pixel to (0,0) regardless of counters.
    always_comb begin
        pos_col = col;
        pos_row = row;
        if (in_sof) begin
            pos_col = '0;
            pos_row = '0;
        end
    end

    // NOTE: the line buffers are read combinationally from their pre-edge
    // contents, so a read and a write to the same column in one cycle
    // returns the old data, which is exactly the read-before-write needed.
    assign l1_rd = l1_mem[pos_col];
    assign l2_rd = l2_mem[pos_col];

    // Window membership and end-of-frame detection for the accepted pixel.
    always_comb begin
        win_hit  = (pos_row >= ROW_FIRST_WIN) && (pos_col >= COL_FIRST_WIN);
        last_hit = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
    end

    // Assemble the window as it will look once the current pixel is shifted
    // in: byte 3*r+k, r=0 oldest row, k=0 leftmost column.
    always_comb begin
        win_next = '0;
        win_next[8*0 +: 8] = top_sr[0];
        win_next[8*1 +: 8] = top_sr[1];
        win_next[8*2 +: 8] = l2_rd;
        win_next[8*3 +: 8] = mid_sr[0];
        win_next[8*4 +: 8] = mid_sr[1];
        win_next[8*5 +: 8] = l1_rd;
        win_next[8*6 +: 8] = bot_sr[0];
        win_next[8*7 +: 8] = bot_sr[1];
        win_next[8*8 +: 8] = gray_in;
    end

    // Raster position counters: column wraps into the next row, row wraps
    // into the next frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (pos_col == COL_LAST) begin
                col <= '0;
                row <= (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
            end else begin
                col <= pos_col + 1'b1;
                row <= pos_row;
            end
        end
    end

    // Line buffer update: push the previous line down and store the new pixel.
    // NOTE: the line memories deliberately have no reset; the window-valid
    // condition guarantees stale contents never reach a valid window, and
    // leaving them unreset lets them map onto plain RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            l2_mem[pos_col] <= l1_rd;
            l1_mem[pos_col] <= gray_in;
        end
    end

    // Column history shift on every accepted pixel; also left unreset.
    always_ff @(posedge clk) begin
        if (accept) begin
            top_sr[0] <= top_sr[1];
            top_sr[1] <= l2_rd;
            mid_sr[0] <= mid_sr[1];
            mid_sr[1] <= l1_rd;
            bot_sr[0] <= bot_sr[1];
            bot_sr[1] <= gray_in;
        end
    end

    // Registered outputs: strobes are single-cycle, the window holds its
    // last value between valid windows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_out    <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid) begin
                if (win_hit) begin
                    win_out   <= win_next;
                    win_valid <= 1'b1;
                end
                frame_done <= last_hit;
            end
        end
    end

endmodule

// File: tb/tb_gray_window_3x3.sv
// tb_gray_window_3x3: directed self-checking bench for gray_window_3x3
// using a 4x4 image and pixel values base + 16*row + col.
module tb_gray_window_3x3;

    localparam int W = 4;
    localparam int H = 4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  gray_in;
    logic        in_valid;
    logic        in_sof;
    logic [71:0] win_out;
    logic        win_valid;
    logic        frame_done;

    int n_checks;
    int n_errors;
    logic [71:0] exp_last;   // window the DUT output should currently hold

    gray_window_3x3 #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gray_in   (gray_in),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .win_out   (win_out),
        .win_valid (win_valid),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected window for the pixel (r,c) of a frame with the given base.
    function automatic logic [71:0] exp_win(input logic [7:0] base, input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int rr = 0; rr < 3; rr++)
            for (int kk = 0; kk < 3; kk++)
                w[8*(3*rr+kk) +: 8] = base + 8'(16*(r-2+rr) + (c-2+kk));
        return w;
    endfunction

    // One clock: inputs already set, sample outputs 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stream one full frame and verify every output cycle.
    task automatic run_frame(input logic [7:0] base, input bit gapped, input bit use_sof,
                             input string name, output logic [71:0] first_win,
                             output logic [71:0] last_win);
        int n_win;
        int n_done;
        logic exp_valid;
        logic exp_done;
        n_win     = 0;
        n_done    = 0;
        first_win = '0;
        last_win  = '0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                in_valid = 1'b1;
                in_sof   = use_sof && (r == 0) && (c == 0);
                gray_in  = base + 8'(16*r + c);
                step();
                exp_valid = (r >= 2) && (c >= 2);
                exp_done  = (r == H-1) && (c == W-1);
                if (exp_valid) exp_last = exp_win(base, r, c);
                n_checks++;
                if (win_valid !== exp_valid) begin
                    n_errors++;
                    $display("FAIL %s win_valid at (%0d,%0d): got %b expected %b", name, r, c, win_valid, exp_valid);
                end
                n_checks++;
                if (frame_done !== exp_done) begin
                    n_errors++;
                    $display("FAIL %s frame_done at (%0d,%0d): got %b expected %b", name, r, c, frame_done, exp_done);
                end
                n_checks++;
                if (win_out !== exp_last) begin
                    n_errors++;
                    $display("FAIL %s win_out at (%0d,%0d): got %h expected %h", name, r, c, win_out, exp_last);
                end
                if (win_valid === 1'b1) begin
                    if (n_win == 0) first_win = win_out;
                    last_win = win_out;
                    n_win++;
                end
                if (frame_done === 1'b1) n_done++;
                if (gapped) begin
                    in_valid = 1'b0;
                    in_sof   = 1'b1;   // sof without valid must be ignored
                    gray_in  = 8'hEE;
                    step();
                    n_checks++;
                    if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
                        n_errors++;
                        $display("FAIL %s idle strobes after (%0d,%0d): got valid=%b done=%b expected 0/0", name, r, c, win_valid, frame_done);
                    end
                    n_checks++;
                    if (win_out !== exp_last) begin
                        n_errors++;
                        $display("FAIL %s idle hold after (%0d,%0d): got %h expected %h", name, r, c, win_out, exp_last);
                    end
                end
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        n_checks++;
        if (n_win != (W-2)*(H-2)) begin
            n_errors++;
            $display("FAIL %s window count: got %0d expected %0d", name, n_win, (W-2)*(H-2));
        end
        n_checks++;
        if (n_done != 1) begin
            n_errors++;
            $display("FAIL %s frame_done count: got %0d expected 1", name, n_done);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_sof   = 1'b1;
        gray_in  = 8'h5A;
        step();
        step();
        n_checks++;
        if (win_out !== 72'h0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset outputs: got win=%h valid=%b done=%b expected 0/0/0", win_out, win_valid, frame_done);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        step();
        n_checks++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset idle: got valid=%b done=%b expected 0/0", win_valid, frame_done);
        end
        exp_last = '0;
    endtask

    task automatic test_continuous();
        logic [71:0] fw;
        logic [71:0] lw;
        run_frame(8'h00, 1'b0, 1'b1, "continuous", fw, lw);
        n_checks++;
        if (fw !== 72'h22_21_20_12_11_10_02_01_00) begin
            n_errors++;
            $display("FAIL continuous first window: got %h expected %h", fw, 72'h222120121110020100);
        end
        n_checks++;
        if (lw !== 72'h33_32_31_23_22_21_13_12_11) begin
            n_errors++;
            $display("FAIL continuous last window: got %h expected %h", lw, 72'h333231232221131211);
        end
    endtask

    task automatic test_gapped();
        logic [71:0] fw;
        logic [71:0] lw;
        run_frame(8'h00, 1'b1, 1'b1, "gapped", fw, lw);
        n_checks++;
        if (fw !== 72'h22_21_20_12_11_10_02_01_00) begin
            n_errors++;
            $display("FAIL gapped first window: got %h expected %h", fw, 72'h222120121110020100);
        end
    endtask

    task automatic test_back_to_back();
        logic [71:0] fw;
        logic [71:0] lw;
        run_frame(8'h00, 1'b0, 1'b1, "b2b_frame1", fw, lw);
        run_frame(8'h80, 1'b0, 1'b1, "b2b_frame2", fw, lw);
        n_checks++;
        if (fw !== 72'hA2_A1_A0_92_91_90_82_81_80) begin
            n_errors++;
            $display("FAIL b2b frame2 first window: got %h expected %h", fw, 72'hA2A1A0929190828180);
        end
    endtask

    // Partial frame up to (1,2), then sof lands on the pixel that would be (1,3).
    task automatic test_midframe_sof();
        logic [71:0] fw;
        logic [71:0] lw;
        for (int i = 0; i < W + 3; i++) begin
            in_valid = 1'b1;
            in_sof   = (i == 0);
            gray_in  = 8'h40 + 8'(16*(i / W) + (i % W));
            step();
            n_checks++;
            if (win_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL pre-sof win_valid at pixel %0d: got %b expected 0", i, win_valid);
            end
        end
        run_frame(8'hA0, 1'b0, 1'b1, "midframe_sof", fw, lw);
        n_checks++;
        if (fw !== 72'hC2_C1_C0_B2_B1_B0_A2_A1_A0) begin
            n_errors++;
            $display("FAIL midframe_sof first window: got %h expected %h", fw, 72'hC2C1C0B2B1B0A2A1A0);
        end
    endtask

    // Reset asserted while pixel (2,1) is presented; then a fresh frame without sof.
    task automatic test_midframe_reset();
        logic [71:0] fw;
        logic [71:0] lw;
        for (int i = 0; i < 2*W + 1; i++) begin
            in_valid = 1'b1;
            in_sof   = (i == 0);
            gray_in  = 8'h50 + 8'(16*(i / W) + (i % W));
            step();
        end
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_sof   = 1'b0;
        gray_in  = 8'h71;
        step();
        exp_last = '0;
        n_checks++;
        if (win_out !== 72'h0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin
            n_errors++;
            $display("FAIL midframe reset outputs: got win=%h valid=%b done=%b expected 0/0/0", win_out, win_valid, frame_done);
        end
        rst_n = 1'b1;
        run_frame(8'h20, 1'b0, 1'b0, "post_reset", fw, lw);
        n_checks++;
        if (lw !== 72'h53_52_51_43_42_41_33_32_31) begin
            n_errors++;
            $display("FAIL post_reset last window: got %h expected %h", lw, 72'h535251434241333231);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_last = '0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        gray_in  = 8'h00;
        test_reset();
        test_continuous();
        test_gapped();
        test_back_to_back();
        test_midframe_sof();
        test_midframe_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
